// File: rtl/keystream_cipher_if.sv
// Valid/ready data stream pair for keystream_cipher: plaintext/ciphertext in, XORed chunks out.
// The master drives input data and output back-pressure; the slave is the cipher datapath.
interface keystream_cipher_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/keystream_cipher.sv
// Stream-cipher datapath: owns the keystream generator's advance strobe, discards the warm-up
// words, then XORs DATA_W-bit slices of each keystream word onto a valid/ready stream.
module keystream_cipher #(
    parameter int KS_W   = 32,
    parameter int DATA_W = 8,
    parameter int WARMUP = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            clear,
    input  logic [KS_W-1:0] ks_in,
    output logic            gen_enable,
    output logic            busy,
    output logic [31:0]     chunk_count,
    keystream_cipher_if.slave bus
);
    localparam int NSLICE  = KS_W / DATA_W;
    localparam int SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NSLICE - 1);
    localparam logic [31:0]        WARM_LAST  = 32'(WARMUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_LOAD   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t              state_r;
    logic [31:0]         warm_cnt_r;
    logic [KS_W-1:0]     ks_reg_r;
    logic [SLICE_W-1:0]  slice_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [31:0]         chunk_count_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                last_slice_s;
    logic                gen_enable_s;

    // Handshake and generator-advance decode; clear suppresses both accept and advance.
    always_comb begin
        in_ready_s   = 1'b0;
        gen_enable_s = 1'b0;
        last_slice_s = (slice_r == SLICE_LAST);
        if ((state_r == ST_RUN) && !clear) begin
            in_ready_s = !out_valid_r || bus.out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = bus.in_valid && in_ready_s;
        if (clear) begin
            gen_enable_s = 1'b0;
        end else begin
            case (state_r)
                ST_WARMUP: gen_enable_s = 1'b1;
                ST_LOAD:   gen_enable_s = 1'b1;
                ST_RUN:    gen_enable_s = accept_s && last_slice_s;
                default:   gen_enable_s = 1'b0;
            endcase
        end
    end

    // Control FSM, keystream slice register and the single output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            warm_cnt_r    <= 32'd0;
            ks_reg_r      <= '0;
            slice_r       <= '0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            chunk_count_r <= 32'd0;
        end else if (clear) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                out_data_r    <= bus.in_data ^ ks_reg_r[DATA_W-1:0];
                out_valid_r   <= 1'b1;
                chunk_count_r <= chunk_count_r + 32'd1;
                // Reload on the last slice so the next chunk sees the new word with no bubble.
                if (last_slice_s) begin
                    ks_reg_r <= ks_in;
                    slice_r  <= '0;
                end else begin
                    ks_reg_r <= ks_reg_r >> DATA_W;
                    slice_r  <= slice_r + SLICE_W'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_WARMUP;
                        warm_cnt_r    <= 32'd0;
                        chunk_count_r <= 32'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WARMUP: begin
                    if (warm_cnt_r == WARM_LAST) begin
                        state_r <= ST_LOAD;
                    end else begin
                        warm_cnt_r <= warm_cnt_r + 32'd1;
                    end
                end
                ST_LOAD: begin
                    ks_reg_r <= ks_in;
                    slice_r  <= '0;
                    state_r  <= ST_RUN;
                end
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign gen_enable    = gen_enable_s;
    assign busy          = (state_r != ST_IDLE);
    assign chunk_count   = chunk_count_r;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_keystream_cipher.sv
// Bench for keystream_cipher: a table-driven generator model feeds ks_in, and a scoreboard
// compares every output chunk against slices of the generator words selected by chunk number.
module tb_keystream_cipher;
    localparam int KS_W   = 32;
    localparam int DATA_W = 8;
    localparam int WARMUP = 4;
    localparam int NSL    = KS_W / DATA_W;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            clear;
    logic [KS_W-1:0] ks_in;
    logic            gen_enable;
    logic            busy;
    logic [31:0]     chunk_count;

    keystream_cipher_if #(.DATA_W(DATA_W)) bus ();

    keystream_cipher #(.KS_W(KS_W), .DATA_W(DATA_W), .WARMUP(WARMUP)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .ks_in(ks_in),
        .gen_enable(gen_enable), .busy(busy), .chunk_count(chunk_count), .bus(bus)
    );

    always #5 clk = ~clk;

    // Generator model: a table of words, index steps on each enabled edge.
    logic [31:0] words [0:1023];
    int          gen_idx = 0;
    always @(posedge clk) if (gen_enable) gen_idx <= gen_idx + 1;
    assign ks_in = words[gen_idx % 1024];

    int          n_cmp = 0;
    int          n_err = 0;
    int          ref_base = 0;
    int          ref_n = 0;
    logic [31:0] cc_model = 32'd0;
    logic [7:0]  sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: push expected chunk on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        logic [31:0] w;
        logic [7:0]  e;
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got out_data %h expected none at %0t", bus.out_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", {24'd0, bus.out_data}, {24'd0, e});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                w = words[(ref_base + ref_n / NSL) % 1024];
                e = w[DATA_W * (ref_n % NSL) +: DATA_W] ^ bus.in_data;
                sb_q.push_back(e);
                check("gen_en_on_accept", {31'd0, gen_enable}, {31'd0, (ref_n % NSL) == NSL - 1});
                ref_n++;
                cc_model = cc_model + 32'd1;
            end
        end
    end

    task automatic begin_start();
        ref_base = gen_idx + WARMUP;
        ref_n    = 0;
        cc_model = 32'd0;
    endtask

    initial begin
        int ge_cnt;
        int ir_cnt;
        for (int i = 0; i < 1024; i++) words[i] = $urandom;
        words[4] = 32'hA1B2C3D4;
        words[5] = 32'h11223344;
        reset = 1'b0; start = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b0;

        #2;
        check("rst_gen_enable", {31'd0, gen_enable}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_chunk_count", chunk_count, 32'd0);
        step(1);
        reset = 1'b1;

        ge_cnt = 0; ir_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (gen_enable) ge_cnt++;
            if (bus.in_ready) ir_cnt++;
        end
        check("idle_gen_enable_cnt", ge_cnt, 0);
        check("idle_in_ready_cnt", ir_cnt, 0);

        // Warm-up: WARMUP advances plus one LOAD advance, then RUN.
        step(1);
        begin_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("warm_gen_enable", {31'd0, gen_enable}, {31'd0, i < WARMUP + 1});
            if (i == 0) check("warm_busy", {31'd0, busy}, 32'd1);
        end

        // Slicing and reload with all-zero data.
        step(1);
        bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.out_ready = 1'b1;
        step(8);
        bus.in_valid = 1'b0;
        step(2);
        check("gen_idx_after_8", gen_idx, WARMUP + 1 + 2);

        // Back-pressure mid-word.
        bus.in_valid = 1'b1;
        bus.in_data = 8'($urandom);
        step(1);
        bus.in_data = 8'($urandom);
        step(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_gen_enable", {31'd0, gen_enable}, 32'd0);
            check("bp_out_data", {24'd0, bus.out_data}, {24'd0, sb_q[0]});
        end
        step(1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'($urandom);
            step(1);
        end

        // Random traffic, with a start pulse in RUN that must be ignored.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            start         = (i == 150);
            step(1);
        end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step(3);
        @(negedge clk);
        check("run_start_busy", {31'd0, busy}, 32'd1);
        check("run_chunk_count", chunk_count, cc_model);
        check("sb_drained", sb_q.size(), 0);
        check("gen_idx_run", gen_idx, ref_base + 1 + ref_n / NSL);

        // Counter wrap.
        step(1);
        force dut.chunk_count_r = 32'hFFFFFFFF;
        step(1);
        release dut.chunk_count_r;
        cc_model = 32'hFFFFFFFF;
        bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
        step(1);
        @(negedge clk);
        check("wrap_chunk_count", chunk_count, 32'h00000000);
        step(1);
        bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
        step(2);

        // Clear in RUN: no accept, no advance, count holds.
        bus.in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        check("clr_run_gen_enable", {31'd0, gen_enable}, 32'd0);
        check("clr_run_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step(1);
        clear = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("clr_run_busy", {31'd0, busy}, 32'd0);
        check("clr_run_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("clr_run_chunk_hold", chunk_count, cc_model);

        // Clear during WARMUP, then start+clear together.
        step(1);
        begin_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        @(negedge clk);
        check("restart_chunk_count", chunk_count, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        step(1);
        clear = 1'b1;
        @(negedge clk);
        check("clr_warm_gen_enable", {31'd0, gen_enable}, 32'd0);
        step(1);
        clear = 1'b0;
        @(negedge clk);
        check("clr_warm_busy", {31'd0, busy}, 32'd0);
        check("clr_warm_gen_idle", {31'd0, gen_enable}, 32'd0);
        step(1);
        start = 1'b1; clear = 1'b1;
        step(1);
        start = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("start_clr_busy", {31'd0, busy}, 32'd0);
        check("start_clr_gen_enable", {31'd0, gen_enable}, 32'd0);

        // Full restart with a generator that was not rewound.
        step(1);
        begin_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        for (int i = 0; i < 100; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_data   = 8'($urandom);
            step(1);
        end

        // Asynchronous reset with an output in flight.
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        step(2);
        check("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_chunk_count", chunk_count, 32'd0);
        check("arst_gen_enable", {31'd0, gen_enable}, 32'd0);
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb_q.delete();
        bus.in_valid = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/keystream_cipher.md
# keystream_cipher

Stream-cipher datapath that sits directly downstream of the keystream generator top. It owns the generator's advance enable and runs the warm-up discard phase. It then slices each keystream word into DATA_W-bit chunks and XORs them onto a valid/ready data stream, one registered output stage deep. It advances the generator only when a full keystream word has been consumed, so no keystream bits are lost under back-pressure.

## Interface
Parameters:
- KS_W, 32, keystream word width; equals the generator's O width.
- DATA_W, 8, data chunk width; KS_W must be an integer multiple of DATA_W.
- WARMUP, 256, number of generator advances discarded after start; must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- clear  in  1  synchronous abort to IDLE from any state.
- ks_in  in  KS_W  keystream word from the generator (its O).
- gen_enable  out  1  advance strobe to the generator; its state steps on each clk edge where this is 1.
- in_valid / in_ready  in / out  1 / 1  input data handshake.
- in_data  in  DATA_W  plaintext or ciphertext chunk.
- out_valid / out_ready  out / in  1 / 1  output data handshake.
- out_data  out  DATA_W  in_data XOR keystream chunk.
- busy  out  1  1 in WARMUP, LOAD or RUN.
- chunk_count  out  32  chunks accepted since the last start; wraps modulo 2^32.

## Operation
- States: IDLE, WARMUP, LOAD, RUN.
- IDLE: gen_enable=0, in_ready=0. start=1 → WARMUP, warm counter cleared to 0, chunk_count cleared to 0.
- WARMUP: gen_enable=1 every cycle; ks_in is ignored. After exactly WARMUP cycles in this state → LOAD.
- LOAD, one cycle:
  - ks_reg ← ks_in (word W0); gen_enable=1.
  - slice index cleared to 0.
  - → RUN.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready.
  - On accept:
    - out_data ← in_data ^ ks_reg[DATA_W-1:0]; out_valid ← 1.
    - chunk_count increments.
    - ks_reg shifts right by DATA_W; slice index increments.
  - Accept on the last slice (index = KS_W/DATA_W−1), same cycle:
    - gen_enable=1.
    - ks_reg ← ks_in (next word); slice index ← 0.
    - Net effect: no bubble.
  - gen_enable is 0 in all other RUN cycles.
- Output register: out_valid drops after out_ready=1 with no new accept. Hold and accept in the same cycle keeps out_valid=1 with the new data.
- clear=1, any state:
  - → IDLE next edge; out_valid ← 0; gen_enable=0 in that cycle.
  - No accept in that cycle: in_ready is forced to 0.
  - chunk_count holds.
- start outside IDLE: ignored. start and clear together: clear wins.
- The generator's own reset is not driven here. Restarting a new key is the integrator's job, by resetting the generator before start.

## Timing
- Reset values:
  - state=IDLE, gen_enable=0, in_ready=0.
  - out_valid=0, out_data=0, busy=0, chunk_count=0.
  - ks_reg=0, slice index=0, warm counter=0.
- start at edge T → WARMUP from cycle T+1.
- gen_enable high for cycles T+1..T+WARMUP (WARMUP cycles), then LOAD at T+WARMUP+1 (one further advance).
- RUN begins T+WARMUP+2; in_ready=1 that cycle (out_valid=0).
- Total discarded advances before the first used word: WARMUP.
- Data latency: accept at edge N → out_valid=1 during cycle N+1.
- Sustained throughput is one chunk per cycle with out_ready held 1.
- gen_enable is combinational from state and accept; in_ready is combinational from out_valid and out_ready.
- Asynchronous reset mid-RUN clears everything, including any output in flight.

## Test plan
- Reset/idle: reset=0 → all outputs 0. Release with no start, 100 cycles → gen_enable never 1, in_ready=0.
- Warm-up count: WARMUP=4, KS_W=32, DATA_W=8, start pulse → gen_enable high exactly 5 consecutive cycles (4 WARMUP + LOAD), busy=1 from the next cycle onward.
- Slicing and reload: ks_in=0xA1B2C3D4 at LOAD, then 0x11223344. Stream in_data=0x00 ×8 with out_ready=1 → out_data 0xD4,0xC3,0xB2,0xA1,0x44,0x33,0x22,0x11. gen_enable=1 only on the 4th and 8th accepts.
- Back-pressure: out_ready=0 for 5 cycles mid-word → in_ready=0 after one accept, out_data held stable, gen_enable=0. Release → sequence resumes without skipped or repeated chunks.
- Clear/start interplay:
  - clear during WARMUP → IDLE next cycle, gen_enable=0.
  - start and clear in the same IDLE cycle → stays IDLE.
  - start in RUN → no effect.
- Counter wrap: force chunk_count to 0xFFFFFFFF, accept one chunk → 0x00000000. A new start → 0.
